// File: rtl/sqrt_pkg.sv
// Widths, counter size and FSM encoding shared by the sqrt unit and its
// radicand-rebuild checker, so root/remainder widths cannot drift apart.
package sqrt_pkg;

  localparam int SQRT_QW = 16;
  localparam int SQRT_RW = SQRT_QW + 1;
  localparam int SQRT_DW = 2 * SQRT_QW;
  localparam int SQRT_CW = $clog2(SQRT_QW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sqrt_state_e;

endpackage

// File: rtl/sqrt_radicand_rebuild.sv
// Rebuilds d = q*q + r from a root/remainder pair with a shift-add multiplier
// and reports whether the pair is a legal square-root result.
module sqrt_radicand_rebuild
  import sqrt_pkg::*;
#(
  parameter int QW = SQRT_QW,
  parameter int RW = QW + 1,
  parameter int DW = 2 * QW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [QW-1:0] q,
  input  logic [RW-1:0] r,
  output logic [DW-1:0] d,
  output logic          ok,
  output logic          busy,
  output logic          ready
);

  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0] LastCnt = CW'(QW - 1);

  sqrt_state_e   state_q, state_d;
  logic [DW:0]   acc_q, acc_d;
  logic [DW:0]   mcand_q, mcand_d;
  logic [QW-1:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] qLat_q, qLat_d;
  logic [RW-1:0] rLat_q, rLat_d;
  logic [DW-1:0] d_q, d_d;
  logic          ok_q, ok_d;
  logic          ready_q, ready_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      qLat_q   <= '0;
      rLat_q   <= '0;
      d_q      <= '0;
      ok_q     <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      qLat_q   <= qLat_d;
      rLat_q   <= rLat_d;
      d_q      <= d_d;
      ok_q     <= ok_d;
      ready_q  <= ready_d;
    end
  end

  // acc starts at r, so only q*q has to be accumulated; the extra top bit
  // catches the single overflowing case q*q + r == 2^DW.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    qLat_d   = qLat_q;
    rLat_d   = rLat_q;
    d_d      = d_q;
    ok_d     = ok_q;
    ready_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = {{(DW + 1 - RW){1'b0}}, r};
          mcand_d  = {{(DW + 1 - QW){1'b0}}, q};
          mplier_d = q;
          cnt_d    = '0;
          qLat_d   = q;
          rLat_d   = r;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = DONE;
        end
      end
      DONE: begin
        d_d     = acc_q[DW-1:0];
        ok_d    = (rLat_q <= {qLat_q, 1'b0}) && !acc_q[DW];
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign d     = d_q;
  assign ok    = ok_q;
  assign ready = ready_q;
  assign busy  = (state_q == CALC);

endmodule

// File: tb/tb_sqrt_radicand_rebuild.sv
// Self-checking bench for sqrt_radicand_rebuild: directed vector table,
// randomized pairs against an arithmetic model, and handshake corner cases.
module tb_sqrt_radicand_rebuild;

  logic        clk;
  logic        clr;
  logic        start;
  logic [15:0] q;
  logic [16:0] r;
  logic [31:0] d;
  logic        ok;
  logic        busy;
  logic        ready;

  int vectors = 0;
  int miscompares = 0;
  int latency;
  int busyCnt;
  logic seen;

  typedef struct {
    logic [15:0] q;
    logic [16:0] r;
    logic [31:0] expD;
    logic        expOk;
  } vec_t;

  vec_t table_v [6];

  sqrt_radicand_rebuild dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .q     (q),
    .r     (r),
    .d     (d),
    .ok    (ok),
    .busy  (busy),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Plain arithmetic reference: full-precision q*q + r, then truncate.
  task automatic refModel(input logic [15:0] qv, input logic [16:0] rv,
                          output logic [31:0] expD, output logic expOk);
    logic [63:0] full;
    full  = 64'(qv) * 64'(qv) + 64'(rv);
    expD  = full[31:0];
    expOk = (64'(rv) <= 64'(qv) * 2) && (full < 64'h1_0000_0000);
  endtask

  task automatic applyStimulus(input logic [15:0] qv, input logic [16:0] rv);
    @(negedge clk);
    q = qv;
    r = rv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busyCnt = busy ? 1 : 0;
    latency = 0;
    seen = 1'b0;
    while (!seen && latency < 40) begin
      @(negedge clk);
      latency++;
      if (ready) seen = 1'b1;
      else if (busy) busyCnt++;
    end
    checkOutput("ready_seen", 64'(seen), 64'd1);
  endtask

  initial begin
    logic [31:0] expD;
    logic        expOk;
    logic [31:0] capD;
    logic        capOk;
    int          pulses;
    int          readyAt [$];

    table_v[0] = '{16'd2645,  17'd3975,   32'd7000000,   1'b1};
    table_v[1] = '{16'd0,     17'd0,      32'd0,         1'b1};
    table_v[2] = '{16'd0,     17'd1,      32'd1,         1'b0};
    table_v[3] = '{16'd65535, 17'd131070, 32'hFFFF_FFFF, 1'b1};
    table_v[4] = '{16'd3,     17'd7,      32'd16,        1'b0};
    table_v[5] = '{16'd65535, 17'd131071, 32'd0,         1'b0};

    clr = 1'b1;
    start = 1'b0;
    q = '0;
    r = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_d", 64'(d), 64'd0);
    checkOutput("reset_ok", 64'(ok), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_ready", 64'(ready), 64'd0);
    clr = 1'b0;

    $display("[TB] directed vectors");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(table_v[i].q, table_v[i].r);
      checkOutput($sformatf("vec%0d_d", i), 64'(d), 64'(table_v[i].expD));
      checkOutput($sformatf("vec%0d_ok", i), 64'(ok), 64'(table_v[i].expOk));
      checkOutput($sformatf("vec%0d_latency", i), 64'(latency), 64'd17);
      checkOutput($sformatf("vec%0d_busycycles", i), 64'(busyCnt), 64'd16);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_ready_width", i), 64'(ready), 64'd0);
    end

    $display("[TB] random vectors");
    for (int i = 0; i < 40; i++) begin
      logic [15:0] qv;
      logic [16:0] rv;
      qv = 16'($urandom_range(0, 65535));
      if (i % 2 == 0) rv = 17'($urandom_range(0, 2 * int'(qv)));
      else rv = 17'($urandom_range(0, 131071));
      refModel(qv, rv, expD, expOk);
      applyStimulus(qv, rv);
      checkOutput($sformatf("rand%0d_d", i), 64'(d), 64'(expD));
      checkOutput($sformatf("rand%0d_ok", i), 64'(ok), 64'(expOk));
    end

    $display("[TB] start while busy");
    @(negedge clk);
    q = 16'd10;
    r = 17'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    q = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    capD = '0;
    capOk = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ready) begin
        pulses++;
        if (pulses == 1) begin
          capD = d;
          capOk = ok;
        end
      end
    end
    checkOutput("busy_start_pulses", 64'(pulses), 64'd1);
    checkOutput("busy_start_d", 64'(capD), 64'd100);
    checkOutput("busy_start_ok", 64'(capOk), 64'd1);
    checkOutput("busy_start_idle", 64'(busy), 64'd0);

    $display("[TB] reset mid-operation");
    @(negedge clk);
    q = 16'd1234;
    r = 17'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_d", 64'(d), 64'd0);
    checkOutput("abort_ok", 64'(ok), 64'd0);
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    checkOutput("abort_no_ready", 64'(pulses), 64'd0);
    applyStimulus(16'd12, 17'd24);
    checkOutput("after_abort_d", 64'(d), 64'd168);
    checkOutput("after_abort_ok", 64'(ok), 64'd1);

    $display("[TB] back-to-back with start held");
    @(negedge clk);
    q = 16'd7;
    r = 17'd14;
    start = 1'b1;
    for (int k = 0; k < 120 && readyAt.size() < 4; k++) begin
      @(negedge clk);
      if (ready) begin
        readyAt.push_back(k);
        checkOutput($sformatf("b2b%0d_d", readyAt.size()), 64'(d), 64'd63);
        checkOutput($sformatf("b2b%0d_ok", readyAt.size()), 64'(ok), 64'd1);
      end
    end
    start = 1'b0;
    checkOutput("b2b_pulse_count", 64'(readyAt.size()), 64'd4);
    for (int j = 1; j < readyAt.size(); j++) begin
      checkOutput($sformatf("b2b_interval%0d", j), 64'(readyAt[j] - readyAt[j-1]), 64'd18);
    end
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
